// File: rtl/wfg_mem_reader_pkg.sv
// Shared types and sizing helpers for the waveform generator SRAM read engine.
package wfg_mem_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned FIFO_PTR_W     = $clog2(FIFO_DEPTH_DEF);

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/wfg_sync_fifo.sv
// Synchronous FIFO with registered head output, synchronous clear and occupancy count.
module wfg_sync_fifo
  import wfg_mem_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        valid,
  output logic [ptr_width(DEPTH):0]   count
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid   = (cnt != '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && valid;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr] <= push_data;
  end

  assign pop_data = valid ? mem[rptr] : '0;
  assign count    = cnt;

endmodule

// File: rtl/wfg_mem_reader.sv
// Streams a circular SRAM address window into a buffered valid/ready interface.
// Optional one-shot mode (single pass, done pulse) enabled by WFG_MEM_READER_ONESHOT_EN.
module wfg_mem_reader
  import wfg_mem_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  io_wbs_clk,
  input  logic                  io_wbs_rst_n,
  input  logic                  cfg_en_i,
  input  logic [ADDR_WIDTH-1:0] cfg_start_addr_i,
  input  logic [ADDR_WIDTH-1:0] cfg_end_addr_i,
`ifdef WFG_MEM_READER_ONESHOT_EN
  input  logic                  cfg_oneshot_i,
  output logic                  done_o,
`endif
  output logic                  csb,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic [DATA_WIDTH-1:0] wfg_tdata_o,
  output logic                  wfg_tvalid_o,
  input  logic                  wfg_tready_i,
  output logic                  busy_o
);

  localparam int unsigned CNT_W = ptr_width(FIFO_DEPTH) + 1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] start_lat;
  logic [ADDR_WIDTH-1:0] end_lat;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  inflight;
  logic                  issue;
  logic                  latch;
  logic                  fifo_clr;
  logic                  fifo_valid;
  logic                  fifo_pop;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        occ;
  logic                  room;
  logic                  stop_issue;
  logic                  start_ok;

  // Outstanding words = buffered + the one returning this cycle.
  assign occ  = {1'b0, fifo_count} + (CNT_W+1)'(inflight);
  assign room = occ < (CNT_W+1)'(FIFO_DEPTH);

`ifdef WFG_MEM_READER_ONESHOT_EN
  logic oneshot_lat;
  logic stop_lat;
  logic rearm_wait;
  logic done_nxt;
  logic done_q;

  assign stop_issue = stop_lat;
  assign start_ok   = !rearm_wait;
  assign done_o     = done_q;
`else
  assign stop_issue = 1'b0;
  assign start_ok   = 1'b1;
`endif

  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    latch     = 1'b0;
    fifo_clr  = 1'b0;
`ifdef WFG_MEM_READER_ONESHOT_EN
    done_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cfg_en_i && start_ok) begin
          latch     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!cfg_en_i) begin
          fifo_clr  = 1'b1;
          state_nxt = FLUSH;
        end else begin
          issue = room && !stop_issue;
`ifdef WFG_MEM_READER_ONESHOT_EN
          if (stop_issue && !inflight && !fifo_valid) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
`endif
        end
      end
      FLUSH: begin
        fifo_clr  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window latch and read pointer; an inverted window collapses onto the start word.
  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      start_lat <= '0;
      end_lat   <= '0;
      rd_ptr    <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (latch) begin
        start_lat <= cfg_start_addr_i;
        end_lat   <= (cfg_end_addr_i < cfg_start_addr_i) ? cfg_start_addr_i : cfg_end_addr_i;
        rd_ptr    <= cfg_start_addr_i;
      end else if (issue) begin
        rd_ptr <= (rd_ptr == end_lat) ? start_lat : rd_ptr + ADDR_WIDTH'(1);
      end
    end
  end

`ifdef WFG_MEM_READER_ONESHOT_EN
  // Single-pass bookkeeping; after done the enable must be seen low before a restart.
  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      oneshot_lat <= 1'b0;
      stop_lat    <= 1'b0;
      rearm_wait  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= done_nxt;
      if (latch) begin
        oneshot_lat <= cfg_oneshot_i;
        stop_lat    <= 1'b0;
      end else if (issue && oneshot_lat && (rd_ptr == end_lat)) begin
        stop_lat <= 1'b1;
      end
      if (done_nxt)       rearm_wait <= 1'b1;
      else if (!cfg_en_i) rearm_wait <= 1'b0;
    end
  end
`endif

  assign fifo_pop = fifo_valid && wfg_tready_i;

  wfg_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (io_wbs_clk),
    .rst_n     (io_wbs_rst_n),
    .clr       (fifo_clr),
    .push      (inflight),
    .push_data (dout),
    .pop       (fifo_pop),
    .pop_data  (wfg_tdata_o),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign csb          = ~issue;
  assign addr         = rd_ptr;
  assign wfg_tvalid_o = fifo_valid;
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_wfg_mem_reader.sv
// Scoreboard bench for wfg_mem_reader: queued expected stream, SRAM model, address/occupancy monitor.
module tb_wfg_mem_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [9:0]  s_addr;
  logic [9:0]  e_addr;
  logic        csb;
  logic [9:0]  addr;
  logic [31:0] dout = '0;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        busy;
`ifdef WFG_MEM_READER_ONESHOT_EN
  logic        oneshot;
  logic        done;
`endif

  logic [31:0] mem [1024];
  logic [31:0] exp_q [$];
  logic [9:0]  exp_rd;
  logic [9:0]  win_s;
  logic [9:0]  win_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          issued = 0;
  int          popped = 0;
  bit          saw_full = 1'b0;

  always #5 clk = ~clk;

  wfg_mem_reader dut (
    .io_wbs_clk       (clk),
    .io_wbs_rst_n     (rst_n),
    .cfg_en_i         (en),
    .cfg_start_addr_i (s_addr),
    .cfg_end_addr_i   (e_addr),
`ifdef WFG_MEM_READER_ONESHOT_EN
    .cfg_oneshot_i    (oneshot),
    .done_o           (done),
`endif
    .csb              (csb),
    .addr             (addr),
    .dout             (dout),
    .wfg_tdata_o      (tdata),
    .wfg_tvalid_o     (tvalid),
    .wfg_tready_i     (tready),
    .busy_o           (busy)
  );

  // One-cycle-latency SRAM read port.
  always @(posedge clk) if (!csb) dout <= mem[addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic arm(input logic [9:0] s, input logic [9:0] e, input int n);
    logic [9:0] a;
    s_addr = s;
    e_addr = e;
    win_s  = s;
    win_e  = (e < s) ? s : e;
    exp_q.delete();
    a = s;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem[a]);
      a = (a == win_e) ? win_s : a + 10'd1;
    end
    exp_rd = s;
    issued = 0;
    popped = 0;
  endtask

  task automatic drop_en();
    @(posedge clk); #1 en = 1'b0;
    repeat (3) @(negedge clk);
    check("drop_busy", busy, 1'b0);
    @(posedge clk); #1;
    exp_q.delete();
    issued = 0;
    popped = 0;
  endtask

  // Monitor: stream scoreboard, address sequence model, and occupancy bound.
  always @(negedge clk) begin
    int occ;
    occ = issued - popped;
    if (tvalid && tready) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL stream_extra: got %h expected no word at %0t", tdata, $time);
      end else begin
        check("stream_data", tdata, exp_q.pop_front());
      end
    end
    if (!csb) begin
      check("issue_addr", addr, exp_rd);
      check("occ_bound", occ < 4, 1'b1);
      exp_rd = (exp_rd == win_e) ? win_s : exp_rd + 10'd1;
      issued++;
    end else if (occ == 4) begin
      saw_full = 1'b1;
    end
    if (tvalid && tready) popped++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | 32'(i);
    mem[10'h010] = 32'h0000_00A0;
    mem[10'h011] = 32'h0000_00A1;
    mem[10'h012] = 32'h0000_00A2;
    mem[10'h013] = 32'h0000_00A3;
    mem[10'h01F] = 32'h0000_DEAD;
    mem[10'h020] = 32'h0000_5A20;
    mem[10'h000] = 32'h0000_0011;
    mem[10'h001] = 32'h0000_0022;
    mem[10'h002] = 32'h0000_0033;
    rst_n = 1'b0; en = 1'b0; tready = 1'b0; s_addr = '0; e_addr = '0;
    win_s = '0; win_e = '0; exp_rd = '0;
`ifdef WFG_MEM_READER_ONESHOT_EN
    oneshot = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_csb", csb, 1'b1);
    check("rst_addr", addr, 10'h000);
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tdata", tdata, 32'h0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Window 0x010..0x013, tready high: latency then one word per cycle.
    arm(10'h010, 10'h013, 60);
    tready = 1'b1;
    en = 1'b1;
    @(negedge clk);
    check("lat_c0_csb", csb, 1'b1);
    check("lat_c0_busy", busy, 1'b0);
    @(negedge clk);
    check("lat_c1_csb", csb, 1'b0);
    check("lat_c1_busy", busy, 1'b1);
    @(negedge clk);
    check("lat_c2_tvalid", tvalid, 1'b0);
    @(negedge clk);
    check("lat_c3_tvalid", tvalid, 1'b1);
    check("lat_c3_tdata", tdata, 32'h0000_00A0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("thru_tvalid", tvalid, 1'b1);
      check("thru_csb", csb, 1'b0);
    end

    // tready toggling: nothing lost, reads throttle at four outstanding.
    @(posedge clk); #1;
    acc0 = n_acc;
    saw_full = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tready = (i % 2 == 1);
      @(posedge clk); #1;
    end
    check("toggle_accepts", 32'(n_acc - acc0), 32'd20);
    check("toggle_saw_full", saw_full, 1'b1);

    // Fill the FIFO, then drop enable.
    tready = 1'b0;
    repeat (8) @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    check("flush_k_tvalid", tvalid, 1'b1);
    check("flush_k_csb", csb, 1'b1);
    @(negedge clk);
    check("flush_k1_tvalid", tvalid, 1'b0);
    check("flush_k1_busy", busy, 1'b1);
    @(negedge clk);
    check("flush_k2_busy", busy, 1'b0);
    @(posedge clk); #1;
    exp_q.delete();
    issued = 0;
    popped = 0;

    // Re-enable resumes from the start address.
    arm(10'h010, 10'h013, 60);
    tready = 1'b1;
    en = 1'b1;
    repeat (2) @(negedge clk);
    check("resume_addr", addr, 10'h010);
    repeat (2) @(negedge clk);
    check("resume_tdata", tdata, 32'h0000_00A0);
    repeat (10) @(negedge clk);
    drop_en();

    // Inverted window: single word loop at 0x020.
    arm(10'h020, 10'h01F, 60);
    en = 1'b1;
    repeat (4) @(negedge clk);
    check("inv_tdata", tdata, 32'h0000_5A20);
    repeat (20) @(negedge clk);
    drop_en();

    // Asynchronous reset mid-stream.
    arm(10'h010, 10'h013, 60);
    en = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1;
    check("arst_csb", csb, 1'b1);
    check("arst_addr", addr, 10'h000);
    check("arst_tvalid", tvalid, 1'b0);
    check("arst_tdata", tdata, 32'h0);
    check("arst_busy", busy, 1'b0);
    exp_q.delete();
    issued = 0;
    popped = 0;
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_tvalid", tvalid, 1'b0);
      check("post_rst_csb", csb, 1'b1);
    end

`ifdef WFG_MEM_READER_ONESHOT_EN
    begin
      int dcount;
      dcount = 0;
      @(posedge clk); #1;
      arm(10'h000, 10'h002, 3);
      oneshot = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        if (done) dcount++;
      end
      @(posedge clk); #1;
      check("oneshot_done_pulses", 32'(dcount), 32'd1);
      check("oneshot_busy", busy, 1'b0);
      check("oneshot_words_left", 32'(exp_q.size()), 32'd0);
      en = 1'b0;
      oneshot = 1'b0;
      @(posedge clk); #1;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
